// File: rtl/kf_gain_update.sv
// Scalar Kalman measurement update built around a combinational Goldschmidt reciprocal.
// Optional KF_GAIN_CLAMP_EN limits the gain to [0, 1.0].
`ifndef FXP_N
`define FXP_N 32
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 16
`endif

module goldschmidt_struct #(
    parameter int N    = `FXP_N,
    parameter int FRAC = `FXP_FRAC
) (
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    localparam int G    = (2*FRAC + 2 > N + 8) ? 2*FRAC + 2 : N + 8;
    localparam int W    = G + 2;
    localparam int ITER = 6;
    localparam int LW   = $clog2(G + N) + 1;
    localparam logic [W:0] Q_MAX = (W+1)'({1'b0, {(N-1){1'b1}}});

    logic [LW-1:0] m;
    logic [LW-1:0] sh;
    logic [N-1:0]  dn;
    logic [W-1:0]  dq;
    logic [W-1:0]  qq;
    logic [W-1:0]  ff;
    logic [W:0]    rnd;

    // Normalise d into [0.5,1), iterate, then undo the normalisation with rounding.
    always_comb begin
        m = '0;
        for (int i = 0; i < N-1; i++)
            if (d[i]) m = i[LW-1:0];
        dn = d << (LW'(N-1) - m);
        dq = {2'b00, dn, {(G-N){1'b0}}};
        qq = W'(1) << G;
        ff = '0;
        for (int k = 0; k < ITER; k++) begin
            ff = (W'(2) << G) - dq;
            qq = W'(({{W{1'b0}}, qq} * {{W{1'b0}}, ff}) >> G);
            dq = W'(({{W{1'b0}}, dq} * {{W{1'b0}}, ff}) >> G);
        end
        sh  = LW'(G - 2*FRAC + 1) + m;
        rnd = ({1'b0, qq} + ((W+1)'(1) << (sh - 1))) >> sh;
        if (d[N-1] || d == '0)
            q = '0;
        else if (rnd > Q_MAX)
            q = Q_MAX[N-1:0];
        else
            q = rnd[N-1:0];
    end
endmodule

module kf_gain_update #(
    parameter int N    = `FXP_N,
    parameter int FRAC = `FXP_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_pred,
    input  logic [N-1:0] p_pred,
    input  logic [N-1:0] z_meas,
    input  logic [N-1:0] r_noise,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] x_upd,
    output logic [N-1:0] p_upd,
    output logic [N-1:0] k_gain,
    output logic         div_err
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SUM   = 3'd1;
    localparam logic [2:0] ST_RECIP = 3'd2;
    localparam logic [2:0] ST_GAIN  = 3'd3;
    localparam logic [2:0] ST_UPD   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};
`ifdef KF_GAIN_CLAMP_EN
    localparam logic [N-1:0] K_ONE = N'(1) << FRAC;
`endif

    logic [2:0]   state;
    logic [N-1:0] x_lat;
    logic [N-1:0] p_lat;
    logic [N-1:0] z_lat;
    logic [N-1:0] r_lat;
    logic [N-1:0] innov;
    logic [N-1:0] s_reg;
    logic         err_reg;
    logic [N-1:0] r_reg;
    logic [N-1:0] k_reg;
    logic [N-1:0] recip_q;
    logic [N-1:0] s_sum;
    logic         s_le0;
    logic [N-1:0] k_mul;
    logic [N-1:0] k_next;

    function automatic logic [N-1:0] sat_as(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic         sub
    );
        logic [N:0] s;
        if (sub)
            s = {a[N-1], a} - {b[N-1], b};
        else
            s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1])
            return s[N] ? S_MIN : S_MAX;
        return s[N-1:0];
    endfunction

    // Full product, floor shift by FRAC, then saturate to N bits.
    function automatic logic [N-1:0] mul(
        input logic [N-1:0] a,
        input logic [N-1:0] b
    );
        logic signed [2*N-1:0] pr;
        logic signed [2*N-1:0] sh;
        pr = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
        sh = pr >>> FRAC;
        if (sh[2*N-1:N-1] == {(N+1){sh[2*N-1]}})
            return sh[N-1:0];
        return sh[2*N-1] ? S_MIN : S_MAX;
    endfunction

    goldschmidt_struct #(
        .N    (N),
        .FRAC (FRAC)
    ) u_recip (
        .d (s_reg),
        .q (recip_q)
    );

    assign in_ready = rst_n && (state == ST_IDLE);
    assign s_sum    = sat_as(p_lat, r_lat, 1'b0);
    assign s_le0    = s_sum[N-1] || (s_sum == '0);
    assign k_mul    = mul(p_lat, r_reg);

    always_comb begin
        k_next = err_reg ? '0 : k_mul;
`ifdef KF_GAIN_CLAMP_EN
        if (!err_reg) begin
            if (k_mul[N-1])
                k_next = '0;
            else if (k_mul > K_ONE)
                k_next = K_ONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            x_lat     <= '0;
            p_lat     <= '0;
            z_lat     <= '0;
            r_lat     <= '0;
            innov     <= '0;
            s_reg     <= '0;
            err_reg   <= 1'b0;
            r_reg     <= '0;
            k_reg     <= '0;
            x_upd     <= '0;
            p_upd     <= '0;
            k_gain    <= '0;
            div_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_lat <= x_pred;
                        p_lat <= p_pred;
                        z_lat <= z_meas;
                        r_lat <= r_noise;
                        state <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    innov   <= sat_as(z_lat, x_lat, 1'b1);
                    s_reg   <= s_sum;
                    err_reg <= s_le0;
                    state   <= ST_RECIP;
                end
                ST_RECIP: begin
                    r_reg <= recip_q;
                    state <= ST_GAIN;
                end
                ST_GAIN: begin
                    k_reg <= k_next;
                    state <= ST_UPD;
                end
                ST_UPD: begin
                    x_upd     <= sat_as(x_lat, mul(k_reg, innov), 1'b0);
                    p_upd     <= sat_as(p_lat, mul(k_reg, p_lat), 1'b1);
                    k_gain    <= k_reg;
                    div_err   <= err_reg;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
